traffic_light_multi_phase: RTL and testbench
============================================

Name: traffic_light_multi_phase

Overview:
Parametrised successor to the two-road traffic-light controller. Serves NUM_DIRS approaches with per-approach vehicle sensors and round-robin arbitration. Green, yellow and all-red intervals are cycle-timed, with a minimum-green floor and a maximum-green ceiling. The parade/hold mode flag (set by P, cleared by R) is integrated into the block. Sits directly under the intersection top level, driven by the system clock.

Parameters:
NUM_DIRS, 4, number of approaches (2..16)
MIN_GREEN, 5, minimum green length in cycles (>=1)
MAX_GREEN, 20, green length in cycles after which a contested green is forced to end (>=MIN_GREEN)
YELLOW_CYCLES, 3, yellow length in cycles (>=1)
ALLRED_CYCLES, 1, all-red length in cycles (0 = ALLRED state skipped)

Ports:
clk  in  1  system clock, rising edge
NOT_RESET  in  1  asynchronous reset, active-low
traffic  in  NUM_DIRS  traffic[i]=1: vehicle waiting/present on approach i
P  in  1  parade request; sets mode
R  in  1  parade release; clears mode
lights  out  2*NUM_DIRS  lights[2i+1:2i] for approach i; 2'b10 green, 2'b01 yellow, 2'b00 red
active_dir  out  $clog2(NUM_DIRS)  approach currently owning the green/yellow
M  out  1  parade mode active

Behaviour:
- Reset (NOT_RESET=0, asynchronous): state GREEN, active_dir=0, timer=0, M=0, next_dir=0. Outputs: approach 0 green, all others red.
- Timer width: $clog2(MAX_GREEN+1). Timer is 0 on entry to each state and increments every cycle; it saturates at MAX_GREEN.
- Mode register: next M = R ? 0 : (P ? 1 : M). R wins when P and R are asserted together. Update is registered, so effect appears one cycle later.
- other_req = |(traffic with bit active_dir masked off).
- GREEN:
  - Exit to YELLOW when all hold: timer >= MIN_GREEN-1, other_req=1, M=0, and (traffic[active_dir]=0 or timer >= MAX_GREEN-1).
  - Green therefore lasts >= MIN_GREEN cycles, and <= MAX_GREEN cycles when contested and M=0.
  - No other_req: green holds indefinitely.
- GREEN->YELLOW transition latches next_dir = first i in active_dir+1, active_dir+2, ... (mod NUM_DIRS) with traffic[i]=1.
  - Later traffic changes do not alter next_dir.
- YELLOW: exactly YELLOW_CYCLES cycles, then ALLRED, or GREEN directly if ALLRED_CYCLES=0.
  - M asserted during YELLOW does not abort the yellow.
- ALLRED: all lights red for exactly ALLRED_CYCLES cycles, then GREEN with active_dir=next_dir and timer=0.
- Parade hold: M=1 blocks only the GREEN exit. A sequence already in YELLOW/ALLRED completes, and the new green is then held until M=0.
- Once M returns to 0, the normal exit condition is re-evaluated the same cycle using the saturated timer. If the timer is past MIN_GREEN, yellow can follow on the next edge.
- Outputs are decoded combinationally from state and active_dir only (Moore).
- Exactly one approach is non-red at any time except in ALLRED.
- Invalid state encodings recover to GREEN on the next edge.

Optional Feature:
TRAFFIC_PREEMPT_EN:
- Defined: adds input preempt (1 bit) and input preempt_dir ($clog2(NUM_DIRS) bits).
  - preempt=1 in GREEN with preempt_dir != active_dir: goes to YELLOW on the next edge, ignoring MIN_GREEN and M, and latches next_dir=preempt_dir.
  - Green on preempt_dir is held while preempt=1, overriding round-robin and MAX_GREEN.
  - preempt during YELLOW/ALLRED overrides the latched next_dir.
- Not defined: ports absent; behaviour exactly as above.

Test Plan:
1. NOT_RESET=0 asynchronously mid-YELLOW of approach 2 -> same cycle lights=8'b00000010 (approach 0 green), active_dir=0, M=0; holds until release.
2. Reset release, traffic=4'b0100 -> approach 0 green cycles 0-4, yellow 5-7, all-red 8, approach 2 green from cycle 9.
3. active_dir=0, traffic=4'b1011 held -> green exactly 20 cycles, then yellow; next green on approach 1.
4. active_dir=3, traffic=4'b0101, approach 3 idle -> wrap-around: next green on approach 0, not 2.
5. Approach 1 green with traffic=4'b1111; pulse P -> M=1 next cycle, green held 100 cycles. Pulse R -> M=0, yellow on the following edge. P and R together -> M ends 0.
6. TRAFFIC_PREEMPT_EN: approach 0 green at timer=1, preempt=1, preempt_dir=3 -> yellow next edge, then all-red, approach 3 green held until preempt=0 even with traffic on others.

Source files
------------

// File: rtl/traffic_light_multi_phase.sv
// ---------------------------------------------------------------------------
// traffic_light_multi_phase
//
// Purpose:
//   Multi-approach traffic-light controller. It serves NUM_DIRS approaches,
//   each with its own vehicle sensor, and hands the green between them in
//   round-robin order. Green, yellow and all-red intervals are timed in clock
//   cycles. Green has a minimum floor (MIN_GREEN) and, when another approach
//   is waiting, a maximum ceiling (MAX_GREEN). A parade/hold mode flag (M),
//   set by P and cleared by R, freezes the current green.
//
// Optional build macro:
//   TRAFFIC_PREEMPT_EN - adds the preempt / preempt_dir inputs. An active
//   preempt forces a handover to preempt_dir (ignoring MIN_GREEN and parade
//   mode) and holds that green for as long as preempt stays high.
//
// Ports:
//   clk          in   1             system clock, rising edge
//   NOT_RESET    in   1             asynchronous reset, active-low
//   traffic      in   NUM_DIRS      traffic[i]=1: vehicle waiting on approach i
//   P            in   1             parade request (sets M)
//   R            in   1             parade release (clears M, wins over P)
//   preempt      in   1             (TRAFFIC_PREEMPT_EN only) preemption request
//   preempt_dir  in   $clog2(N)     (TRAFFIC_PREEMPT_EN only) approach to serve
//   lights       out  2*NUM_DIRS    lights[2i+1:2i]: 10 green, 01 yellow, 00 red
//   active_dir   out  $clog2(N)     approach owning the green/yellow
//   M            out  1             parade mode active
// ---------------------------------------------------------------------------
module traffic_light_multi_phase #(
    parameter int NUM_DIRS      = 4,
    parameter int MIN_GREEN     = 5,
    parameter int MAX_GREEN     = 20,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        NOT_RESET,
    input  logic [NUM_DIRS-1:0]         traffic,
    input  logic                        P,
    input  logic                        R,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                        preempt,
    input  logic [$clog2(NUM_DIRS)-1:0] preempt_dir,
`endif
    output logic [2*NUM_DIRS-1:0]       lights,
    output logic [$clog2(NUM_DIRS)-1:0] active_dir,
    output logic                        M
);

    localparam int DW = $clog2(NUM_DIRS);

    // The timer is shared by all three states, so it must be wide enough for
    // the longest interval. With the default parameters this is MAX_GREEN.
    localparam int TMAX_A = (MAX_GREEN > YELLOW_CYCLES) ? MAX_GREEN : YELLOW_CYCLES;
    localparam int TMAX   = (TMAX_A > ALLRED_CYCLES) ? TMAX_A : ALLRED_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);
    localparam logic [TW-1:0] MIN_LAST  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'((ALLRED_CYCLES > 0) ? ALLRED_CYCLES - 1 : 0);

    // The unused encoding 2'b11 is caught by the default branch below and
    // steers the machine back to GREEN.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        ALLRED = 2'b10
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [DW-1:0]   next_dir, next_dir_n;
    logic [DW-1:0]   active_dir_n;
    logic            mode, mode_n;

    logic [NUM_DIRS-1:0] others;
    logic                other_req;
    logic [DW-1:0]       rr_pick;
    logic                rr_found;
    logic                green_exit;
    logic                exit_normal;
    logic [DW-1:0]       handover_dir;
    logic [DW-1:0]       exit_dir;

    // Register bank: state, interval timer, the current and the latched next
    // approach, and the parade mode flag. Everything returns to "approach 0
    // green, timer cleared, no parade" on an asynchronous reset.
    always_ff @(posedge clk or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            state      <= GREEN;
            timer      <= '0;
            active_dir <= '0;
            next_dir   <= '0;
            mode       <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            active_dir <= active_dir_n;
            next_dir   <= next_dir_n;
            mode       <= mode_n;
        end
    end

    assign M = mode;

    // Demand from any approach other than the one currently served.
    always_comb begin
        others             = traffic;
        others[active_dir] = 1'b0;
        other_req          = |others;
    end

    // Round-robin search: the first requesting approach after active_dir,
    // wrapping past the highest index back to 0.
    always_comb begin
        rr_pick  = active_dir;
        rr_found = 1'b0;
        for (int k = 1; k < NUM_DIRS; k++) begin
            int idx;
            idx = int'(active_dir) + k;
            if (idx >= NUM_DIRS) begin
                idx = idx - NUM_DIRS;
            end
            if (!rr_found && traffic[idx]) begin
                rr_pick  = DW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    // Ordinary green-exit rule: the minimum green has elapsed, someone else is
    // waiting, no parade hold, and either this approach went idle or the
    // green has run to its ceiling.
    assign exit_normal = (timer >= MIN_LAST) && other_req && !mode &&
                         (!traffic[active_dir] || (timer >= MAX_LAST));

`ifdef TRAFFIC_PREEMPT_EN
    // Preemption toward a different approach ends the green at once; a
    // preemption naming the current approach pins the green in place.
    assign green_exit   = preempt ? (preempt_dir != active_dir) : exit_normal;
    assign exit_dir     = preempt ? preempt_dir : rr_pick;
    assign handover_dir = preempt ? preempt_dir : next_dir;
`else
    assign green_exit   = exit_normal;
    assign exit_dir     = rr_pick;
    assign handover_dir = next_dir;
`endif

    // Next-state logic. The timer is restarted on every state change and
    // otherwise counts up and sticks at its ceiling, so a long-held green
    // still remembers that MIN_GREEN and MAX_GREEN have passed.
    always_comb begin
        state_n      = state;
        timer_n      = (timer == TIMER_SAT) ? timer : timer + 1'b1;
        active_dir_n = active_dir;
        next_dir_n   = next_dir;
        mode_n       = R ? 1'b0 : (P ? 1'b1 : mode);

        case (state)
            GREEN: begin
                if (green_exit) begin
                    state_n    = YELLOW;
                    timer_n    = '0;
                    next_dir_n = exit_dir;
                end
            end
            YELLOW: begin
                next_dir_n = handover_dir;
                if (timer >= Y_LAST) begin
                    timer_n = '0;
                    if (ALLRED_CYCLES == 0) begin
                        state_n      = GREEN;
                        active_dir_n = handover_dir;
                    end else begin
                        state_n = ALLRED;
                    end
                end
            end
            ALLRED: begin
                next_dir_n = handover_dir;
                if (timer >= AR_LAST) begin
                    state_n      = GREEN;
                    timer_n      = '0;
                    active_dir_n = handover_dir;
                end
            end
            default: begin
                state_n = GREEN;
                timer_n = '0;
            end
        endcase
    end

    // Moore light decode: only the active approach can be non-red, and during
    // ALLRED (or an invalid state) every approach shows red.
    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (DW'(i) == active_dir) begin
                if (state == GREEN) begin
                    lights[2*i +: 2] = 2'b10;
                end else if (state == YELLOW) begin
                    lights[2*i +: 2] = 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_multi_phase.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_multi_phase
//
// Purpose:
//   Self-checking bench for traffic_light_multi_phase with the default
//   parameters (4 approaches, MIN 5, MAX 20, yellow 3, all-red 1). A run-length
//   vector table walks the controller through round-robin handovers, then
//   hand-written sequences cover parade hold, asynchronous reset mid-yellow
//   and, when TRAFFIC_PREEMPT_EN is defined, preemption.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_traffic_light_multi_phase;

    logic       clk;
    logic       NOT_RESET;
    logic [3:0] traffic;
    logic       P;
    logic       R;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic       M;
`ifdef TRAFFIC_PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_dir;
`endif

    int total;
    int bad;

    // One record holds the inputs for a run of n cycles and the outputs
    // expected after each of those cycles.
    typedef struct {
        logic [3:0] traffic;
        logic       p;
        logic       r;
        int         n;
        logic [7:0] lights;
        logic [1:0] dir;
        logic       m;
    } vec_t;

    vec_t vecs [21];

    traffic_light_multi_phase #(
        .NUM_DIRS      (4),
        .MIN_GREEN     (5),
        .MAX_GREEN     (20),
        .YELLOW_CYCLES (3),
        .ALLRED_CYCLES (1)
    ) dut (
        .clk         (clk),
        .NOT_RESET   (NOT_RESET),
        .traffic     (traffic),
        .P           (P),
        .R           (R),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt     (preempt),
        .preempt_dir (preempt_dir),
`endif
        .lights      (lights),
        .active_dir  (active_dir),
        .M           (M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle's inputs at the falling edge, let the rising edge act,
    // and return at the next falling edge where outputs are stable.
    task automatic applyStimulus(input logic [3:0] t, input logic p, input logic r);
        traffic = t;
        P       = p;
        R       = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_lights,
                               input logic [1:0] exp_dir, input logic exp_m);
        total++;
        if (lights !== exp_lights || active_dir !== exp_dir || M !== exp_m) begin
            bad++;
            $display("[TB] FAIL %s: got lights=%b dir=%0d M=%b, expected lights=%b dir=%0d M=%b",
                     name, lights, active_dir, M, exp_lights, exp_dir, exp_m);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        NOT_RESET = 1'b0;
        traffic   = 4'b0000;
        P         = 1'b0;
        R         = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
        preempt     = 1'b0;
        preempt_dir = 2'd0;
`endif

        // Cycle numbers in the comments count from reset release (cycle 0).
        // Approach 2 alone waiting: green0 1-4, yellow0 5-7, all-red 8, green2 at 9.
        vecs[0]  = '{4'b0100, 1'b0, 1'b0,  4, 8'h02, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 1'b0, 1'b0,  3, 8'h01, 2'd0, 1'b0};
        vecs[2]  = '{4'b0100, 1'b0, 1'b0,  1, 8'h00, 2'd0, 1'b0};
        vecs[3]  = '{4'b0100, 1'b0, 1'b0,  1, 8'h20, 2'd2, 1'b0};
        // Only approach 3 waiting: green2 ends at the minimum, green3 at 18.
        vecs[4]  = '{4'b1000, 1'b0, 1'b0,  4, 8'h20, 2'd2, 1'b0};
        vecs[5]  = '{4'b1000, 1'b0, 1'b0,  3, 8'h10, 2'd2, 1'b0};
        vecs[6]  = '{4'b1000, 1'b0, 1'b0,  1, 8'h00, 2'd2, 1'b0};
        vecs[7]  = '{4'b1000, 1'b0, 1'b0,  1, 8'h80, 2'd3, 1'b0};
        // Wrap-around: approach 3 idle, 0 and 2 waiting, so 0 is next.
        vecs[8]  = '{4'b0101, 1'b0, 1'b0,  4, 8'h80, 2'd3, 1'b0};
        vecs[9]  = '{4'b0101, 1'b0, 1'b0,  3, 8'h40, 2'd3, 1'b0};
        vecs[10] = '{4'b0101, 1'b0, 1'b0,  1, 8'h00, 2'd3, 1'b0};
        vecs[11] = '{4'b0101, 1'b0, 1'b0,  1, 8'h02, 2'd0, 1'b0};
        // Contested green on 0 runs exactly 20 cycles (27-46), then 1 is next.
        vecs[12] = '{4'b1011, 1'b0, 1'b0, 19, 8'h02, 2'd0, 1'b0};
        vecs[13] = '{4'b1011, 1'b0, 1'b0,  3, 8'h01, 2'd0, 1'b0};
        vecs[14] = '{4'b1011, 1'b0, 1'b0,  1, 8'h00, 2'd0, 1'b0};
        vecs[15] = '{4'b1011, 1'b0, 1'b0,  1, 8'h08, 2'd1, 1'b0};
        // Nobody else waiting: green on 1 holds far beyond MAX_GREEN.
        vecs[16] = '{4'b0010, 1'b0, 1'b0, 30, 8'h08, 2'd1, 1'b0};
        // Mode flag: P sets it a cycle later, P with R together clears it.
        vecs[17] = '{4'b0010, 1'b1, 1'b0,  1, 8'h08, 2'd1, 1'b1};
        vecs[18] = '{4'b0010, 1'b0, 1'b0,  3, 8'h08, 2'd1, 1'b1};
        vecs[19] = '{4'b0010, 1'b1, 1'b1,  1, 8'h08, 2'd1, 1'b0};
        vecs[20] = '{4'b0010, 1'b0, 1'b1,  1, 8'h08, 2'd1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_held", 8'h02, 2'd0, 1'b0);
        NOT_RESET = 1'b1;
        checkOutput("reset_release", 8'h02, 2'd0, 1'b0);

        for (int v = 0; v < 21; v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                applyStimulus(vecs[v].traffic, vecs[v].p, vecs[v].r);
                checkOutput($sformatf("vec%0d_c%0d", v, c),
                            vecs[v].lights, vecs[v].dir, vecs[v].m);
            end
        end

        // Parade hold on a fully contested green of approach 1.
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("parade_set", 8'h08, 2'd1, 1'b1);
        for (int c = 0; c < 100; c++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0);
            checkOutput($sformatf("parade_hold_c%0d", c), 8'h08, 2'd1, 1'b1);
        end
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("parade_release", 8'h08, 2'd1, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("release_yellow", 8'h04, 2'd1, 1'b0);

        // Parade requested mid-yellow: yellow and all-red still complete,
        // then the new green on approach 2 is frozen.
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("yellow_parade_y1", 8'h04, 2'd1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("yellow_parade_y2", 8'h04, 2'd1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("yellow_parade_ar", 8'h00, 2'd1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("yellow_parade_g2", 8'h20, 2'd2, 1'b1);
        for (int c = 0; c < 30; c++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0);
            checkOutput($sformatf("g2_hold_c%0d", c), 8'h20, 2'd2, 1'b1);
        end
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("g2_release", 8'h20, 2'd2, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("g2_yellow", 8'h10, 2'd2, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("g2_yellow_mode", 8'h10, 2'd2, 1'b1);

        // Asynchronous reset in the middle of approach 2's yellow.
        P = 1'b0;
        #2 NOT_RESET = 1'b0;
        #1 checkOutput("async_reset", 8'h02, 2'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("reset_hold_c%0d", c), 8'h02, 2'd0, 1'b0);
        end
        NOT_RESET = 1'b1;
        checkOutput("reset_release2", 8'h02, 2'd0, 1'b0);

`ifdef TRAFFIC_PREEMPT_EN
        // Preemption toward approach 3 after one green cycle on approach 0.
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_green_t1", 8'h02, 2'd0, 1'b0);
        preempt     = 1'b1;
        preempt_dir = 2'd3;
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_yellow0", 8'h01, 2'd0, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_yellow1", 8'h01, 2'd0, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_yellow2", 8'h01, 2'd0, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_allred", 8'h00, 2'd0, 1'b0);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_green3", 8'h80, 2'd3, 1'b0);
        for (int c = 0; c < 30; c++) begin
            applyStimulus(4'b0111, 1'b0, 1'b0);
            checkOutput($sformatf("pre_hold_c%0d", c), 8'h80, 2'd3, 1'b0);
        end
        preempt = 1'b0;
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("pre_end_yellow3", 8'h40, 2'd3, 1'b0);
`else
        // Without preemption, an uncontested green on 0 simply holds.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
            checkOutput($sformatf("post_reset_c%0d", c), 8'h02, 2'd0, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
